// File: rtl/i2c_bit_sequencer.sv
// Bit-level I2C master: runs one register write or read frame per accepted request and
// drives open-drain SCL/SDA enables; reports slave NACKs and returns the read byte.
module i2c_bit_sequencer #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       i_clk,
    input  logic       reset_n,
    input  logic [7:0] i_addr_w_rw,
    input  logic [7:0] i_sub_addr,
    input  logic [7:0] i_data_write,
    input  logic       req_trans,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int unsigned QW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] QMax = QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        StIdle, StStart, StAddr, StAckA, StSub, StAckS, StWdata, StAckW,
        StRstart, StRaddr, StAckR, StRdata, StMnack, StStop, StFin
    } state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      addr_q, addr_d, sub_q, sub_d, wdata_q, wdata_d;
    logic [7:0]      rx_q, rx_d, data_q, data_d;
    logic            ack_err_q, ack_err_d;
    logic            sda_q;
    logic            in_slot, q_last, sample_pt, slot_end, ack_slot;
    logic [7:0]      tx_byte;
    logic            tx_bit;

    assign in_slot   = (state_q != StIdle) && (state_q != StFin);
    assign q_last    = (qcnt_q == QMax);
    assign sample_pt = q_last && (phase_q == 2'd2);
    assign slot_end  = q_last && (phase_q == 2'd3);
    assign ack_slot  = state_q inside {StAckA, StAckS, StAckW, StAckR};

    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            qcnt_q    <= '0;
            phase_q   <= 2'd0;
            bit_q     <= 3'd0;
            addr_q    <= 8'h00;
            sub_q     <= 8'h00;
            wdata_q   <= 8'h00;
            rx_q      <= 8'h00;
            data_q    <= 8'h00;
            ack_err_q <= 1'b0;
            sda_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            addr_q    <= addr_d;
            sub_q     <= sub_d;
            wdata_q   <= wdata_d;
            rx_q      <= rx_d;
            data_q    <= data_d;
            ack_err_q <= ack_err_d;
            // Remembers the SDA level driven last cycle so Q0 of each slot can hold it.
            sda_q     <= sda_oe;
        end
    end

    always_comb begin
        unique case (state_q)
            StAddr:  tx_byte = {addr_q[7:1], 1'b0};
            StSub:   tx_byte = sub_q;
            StWdata: tx_byte = wdata_q;
            StRaddr: tx_byte = {addr_q[7:1], 1'b1};
            default: tx_byte = 8'h00;
        endcase
        tx_bit = tx_byte[3'd7 - bit_q];
    end

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        addr_d    = addr_q;
        sub_d     = sub_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        data_d    = data_q;
        ack_err_d = ack_err_q;

        if (in_slot) begin
            if (q_last) begin
                qcnt_d  = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                qcnt_d = qcnt_q + 1'b1;
            end
        end
        if (sample_pt && ack_slot && sda_i) ack_err_d = 1'b1;
        if (sample_pt && (state_q == StRdata)) rx_d = {rx_q[6:0], sda_i};

        unique case (state_q)
            StIdle: begin
                if (req_trans) begin
                    addr_d    = i_addr_w_rw;
                    sub_d     = i_sub_addr;
                    wdata_d   = i_data_write;
                    ack_err_d = 1'b0;
                    qcnt_d    = '0;
                    phase_d   = 2'd0;
                    bit_d     = 3'd0;
                    state_d   = StStart;
                end
            end
            StStart:  if (slot_end) state_d = StAddr;
            StRstart: if (slot_end) state_d = StRaddr;
            StAddr, StSub, StWdata, StRaddr, StRdata: begin
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        unique case (state_q)
                            StAddr:  state_d = StAckA;
                            StSub:   state_d = StAckS;
                            StWdata: state_d = StAckW;
                            StRaddr: state_d = StAckR;
                            default: state_d = StMnack;
                        endcase
                    end
                end
            end
            // ack_err_q already reflects this slot's sample by the end of Q3.
            StAckA: if (slot_end) state_d = ack_err_q ? StStop : StSub;
            StAckS: begin
                if (slot_end) state_d = ack_err_q ? StStop : (addr_q[0] ? StRstart : StWdata);
            end
            StAckR: if (slot_end) state_d = ack_err_q ? StStop : StRdata;
            StAckW, StMnack: if (slot_end) state_d = StStop;
            StStop: begin
                if (slot_end) begin
                    state_d = StFin;
                    if (addr_q[0] && !ack_err_q) data_d = rx_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (state_q)
            StStart: sda_oe = phase_q[1];
            StRstart: begin
                scl_oe = (phase_q == 2'd0);
                sda_oe = (phase_q == 2'd0) ? sda_q : (phase_q == 2'd3);
            end
            StStop: begin
                scl_oe = ~phase_q[1];
                sda_oe = (phase_q == 2'd0) ? sda_q : (phase_q != 2'd3);
            end
            StAddr, StSub, StWdata, StRaddr: begin
                scl_oe = ~phase_q[1];
                sda_oe = (phase_q == 2'd0) ? sda_q : ~tx_bit;
            end
            StAckA, StAckS, StAckW, StAckR, StRdata, StMnack: begin
                scl_oe = ~phase_q[1];
                sda_oe = (phase_q == 2'd0) ? sda_q : 1'b0;
            end
            default: ;
        endcase
    end

    assign busy      = in_slot;
    assign done      = (state_q == StFin);
    assign valid_out = done && addr_q[0] && !ack_err_q;
    assign ack_err   = ack_err_q;
    assign data_out  = data_q;

endmodule
